// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Next-PC source select driven into the PC mux.
  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_EXC = 2'b10,
    PC_SEL_RST = 2'b11
  } pc_sel_e;

  // Mult/div occupancy FSM states.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam int          MD_CNT_W   = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard inputs and PC/IF-ID control outputs of the hazard controller.
// master = pipeline side, slave = the controller.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        id_md_op;
  logic        id_md_use;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        exc_req;

  logic        pc_we;
  pc_sel_e     pc_sel;
  logic [31:0] redirect_pc;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        md_busy;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rd_addr,
           id_md_op, id_md_use, id_branch_taken, id_branch_target, exc_req,
    input  pc_we, pc_sel, redirect_pc, ifid_we, ifid_flush, idex_flush, md_busy
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rd_addr,
           id_md_op, id_md_use, id_branch_taken, id_branch_target, exc_req,
    output pc_we, pc_sel, redirect_pc, ifid_we, ifid_flush, idex_flush, md_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use against the EX load, and HI/LO
// access while the mult/div unit is still working.
module hazard_detect (
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       md_busy,
  input  logic       id_md_use,
  output logic       stall
);

  logic lu_haz;
  logic md_haz;

  // $zero is never a real producer, so a load targeting r0 cannot hazard.
  assign lu_haz = ex_mem_read && (ex_rd_addr != 5'd0) &&
                  ((ex_rd_addr == id_rs_addr) ||
                   (id_uses_rt && (ex_rd_addr == id_rt_addr)));

  assign md_haz = md_busy && id_md_use;

  assign stall  = lu_haz || md_haz;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect scheduler for the 5-stage MIPS32 pipeline.
// Priority: reset > exception > stall > taken branch > sequential.
// Optional macro PIPE_PERF_CNT_EN adds stall/flush performance counters.
// MD_LAT legal range is 1..15 (4-bit counter).
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT     = 4,
  parameter logic [31:0] EXC_VECTOR = pipe_pkg::EXC_VECTOR,
  parameter logic [31:0] RESET_PC   = pipe_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  import pipe_pkg::*;

  localparam logic [MD_CNT_W-1:0] MD_LAT_CNT = MD_LAT[MD_CNT_W-1:0];

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_busy;
  logic                stall;
  logic                md_issue;

  // Busy is forced low during reset so outputs are clean before the first edge.
  assign md_busy     = !rst && (md_cnt_q != '0);
  assign bus.md_busy = md_busy;

  hazard_detect u_hazard_detect (
    .id_rs_addr  (bus.id_rs_addr),
    .id_rt_addr  (bus.id_rt_addr),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd_addr  (bus.ex_rd_addr),
    .md_busy     (md_busy),
    .id_md_use   (bus.id_md_use),
    .stall       (stall)
  );

  // A mult/div leaves ID only when nothing holds or squashes it.
  assign md_issue = bus.id_md_op && !stall && !bus.exc_req;

  // State register for the mult/div occupancy FSM and its countdown.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state: load latency on issue, count down to zero while busy.
  // Exceptions do not cancel the mult/div unit, so counting continues.
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (md_issue) begin
          state_d  = ST_MD_BUSY;
          md_cnt_d = MD_LAT_CNT;
        end
      end
      ST_MD_BUSY: begin
        if (md_cnt_q <= 1) begin
          state_d  = ST_RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // Priority mux driving PC write-enable, next-PC select and pipeline flushes.
  always_comb begin
    bus.pc_we       = 1'b1;
    bus.pc_sel      = PC_SEL_SEQ;
    bus.redirect_pc = '0;
    bus.ifid_we     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    if (rst) begin
      bus.pc_sel      = PC_SEL_RST;
      bus.redirect_pc = RESET_PC;
      bus.ifid_we     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
    end else if (bus.exc_req) begin
      // Both young stages are squashed; the flush loads the bubble.
      bus.pc_sel      = PC_SEL_EXC;
      bus.redirect_pc = EXC_VECTOR;
      bus.ifid_we     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
    end else if (stall) begin
      // Hold PC and IF/ID; a pending branch re-resolves next cycle.
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.idex_flush = 1'b1;
    end else if (bus.id_branch_taken) begin
      // Delay-slot instruction already in IF proceeds, so no IF/ID flush.
      bus.pc_sel      = PC_SEL_BR;
      bus.redirect_pc = bus.id_branch_target;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters: stall cycles not overridden by an exception, and
  // exception flush cycles. Both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && !bus.exc_req) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.exc_req)           perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (MD_LAT=4 and 1)
// share stimulus; a per-cycle reference model pushes expected outputs into
// queues that a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        mem_read;
    logic [4:0]  rd;
    logic        md_op;
    logic        md_use;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [31:0] redirect_pc;
    logic        ifid_we;
    logic        chk_ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_busy;
    longint      stall_cnt;
    longint      flush_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus_a ();
  pipe_hazard_ctrl_if bus_b ();

  logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;

  pipe_hazard_ctrl #(.MD_LAT(LAT_A)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_a)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_a),
    .perf_flush_cnt (perf_flush_a)
`endif
  );

  pipe_hazard_ctrl #(.MD_LAT(LAT_B)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_b)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_b),
    .perf_flush_cnt (perf_flush_b)
`endif
  );

`ifndef PIPE_PERF_CNT_EN
  assign perf_stall_a = '0;
  assign perf_flush_a = '0;
  assign perf_stall_b = '0;
  assign perf_flush_b = '0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state per instance: cycles of mult/div still running,
  // and event counts (-1 = unknown until the first reset).
  int     busy_left[2] = '{0, 0};
  longint stall_n[2]   = '{-1, -1};
  longint flush_n[2]   = '{-1, -1};

  task automatic check(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, req);
    end
  endtask

  // Expected outputs from the priority rules, given the inputs and how many
  // mult/div cycles remain.
  function automatic exp_t predict(input stim_t s, input int busy,
                                   input longint sc, input longint fc);
    exp_t e;
    bit   lu, st;
    lu = s.mem_read && (s.rd != 0) &&
         ((s.rd == s.rs) || (s.uses_rt && (s.rd == s.rt)));
    st = lu || ((busy > 0) && s.md_use);
    e.cyc         = cyc;
    e.pc_we       = 1'b1;
    e.pc_sel      = 2'b00;
    e.redirect_pc = 32'h0;
    e.ifid_we     = 1'b1;
    e.chk_ifid_we = 1'b1;
    e.ifid_flush  = 1'b0;
    e.idex_flush  = 1'b0;
    e.md_busy     = !s.rst && (busy > 0);
    e.stall_cnt   = sc;
    e.flush_cnt   = fc;
    if (s.rst) begin
      e.pc_sel = 2'b11; e.redirect_pc = 32'h0000_3000; e.ifid_we = 1'b0;
      e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
    end else if (s.exc) begin
      e.pc_sel = 2'b10; e.redirect_pc = 32'h0000_4180; e.chk_ifid_we = 1'b0;
      e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
    end else if (st) begin
      e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idex_flush = 1'b1;
    end else if (s.br) begin
      e.pc_sel = 2'b01; e.redirect_pc = s.tgt;
    end
    return e;
  endfunction

  // Advance one instance's model across a clock edge.
  task automatic model_step(input stim_t s, input int idx, input int lat);
    bit lu, st;
    lu = s.mem_read && (s.rd != 0) &&
         ((s.rd == s.rs) || (s.uses_rt && (s.rd == s.rt)));
    st = lu || ((busy_left[idx] > 0) && s.md_use);
    if (s.rst) begin
      busy_left[idx] = 0; stall_n[idx] = 0; flush_n[idx] = 0;
    end else begin
      if (busy_left[idx] > 0)            busy_left[idx]--;
      else if (s.md_op && !st && !s.exc) busy_left[idx] = lat;
      if (stall_n[idx] >= 0 && st && !s.exc) stall_n[idx]++;
      if (flush_n[idx] >= 0 && s.exc)        flush_n[idx]++;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rs = 5'd1; s.rt = 5'd2; s.uses_rt = 0; s.mem_read = 0;
    s.rd = 5'd0; s.md_op = 0; s.md_use = 0; s.br = 0; s.tgt = 32'h0; s.exc = 0;
    return s;
  endfunction

  // Apply one cycle of stimulus to both instances and queue expectations.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst;
    bus_a.id_rs_addr = s.rs;       bus_b.id_rs_addr = s.rs;
    bus_a.id_rt_addr = s.rt;       bus_b.id_rt_addr = s.rt;
    bus_a.id_uses_rt = s.uses_rt;  bus_b.id_uses_rt = s.uses_rt;
    bus_a.ex_mem_read = s.mem_read; bus_b.ex_mem_read = s.mem_read;
    bus_a.ex_rd_addr = s.rd;       bus_b.ex_rd_addr = s.rd;
    bus_a.id_md_op = s.md_op;      bus_b.id_md_op = s.md_op;
    bus_a.id_md_use = s.md_use;    bus_b.id_md_use = s.md_use;
    bus_a.id_branch_taken = s.br;  bus_b.id_branch_taken = s.br;
    bus_a.id_branch_target = s.tgt; bus_b.id_branch_target = s.tgt;
    bus_a.exc_req = s.exc;         bus_b.exc_req = s.exc;
    q_a.push_back(predict(s, busy_left[0], stall_n[0], flush_n[0]));
    q_b.push_back(predict(s, busy_left[1], stall_n[1], flush_n[1]));
    model_step(s, 0, LAT_A);
    model_step(s, 1, LAT_B);
  endtask

  task automatic compare(input string tag, input exp_t e,
                         input logic pc_we, input logic [1:0] pc_sel,
                         input logic [31:0] rpc, input logic ifid_we,
                         input logic ifid_fl, input logic idex_fl,
                         input logic md_busy, input logic [31:0] ps,
                         input logic [31:0] pf);
    check({tag, ".pc_we"},       e.cyc, {31'b0, pc_we},   {31'b0, e.pc_we});
    check({tag, ".pc_sel"},      e.cyc, {30'b0, pc_sel},  {30'b0, e.pc_sel});
    check({tag, ".redirect_pc"}, e.cyc, rpc,              e.redirect_pc);
    if (e.chk_ifid_we)
      check({tag, ".ifid_we"},   e.cyc, {31'b0, ifid_we}, {31'b0, e.ifid_we});
    check({tag, ".ifid_flush"},  e.cyc, {31'b0, ifid_fl}, {31'b0, e.ifid_flush});
    check({tag, ".idex_flush"},  e.cyc, {31'b0, idex_fl}, {31'b0, e.idex_flush});
    check({tag, ".md_busy"},     e.cyc, {31'b0, md_busy}, {31'b0, e.md_busy});
`ifdef PIPE_PERF_CNT_EN
    if (e.stall_cnt >= 0)
      check({tag, ".perf_stall"}, e.cyc, ps, e.stall_cnt[31:0]);
    if (e.flush_cnt >= 0)
      check({tag, ".perf_flush"}, e.cyc, pf, e.flush_cnt[31:0]);
`else
    if (ps !== 32'h0 || pf !== 32'h0) check({tag, ".perf_absent"}, e.cyc, ps | pf, 32'h0);
`endif
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the
  // oldest pending expectation for each instance.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      compare("a", e, bus_a.pc_we, bus_a.pc_sel, bus_a.redirect_pc,
              bus_a.ifid_we, bus_a.ifid_flush, bus_a.idex_flush,
              bus_a.md_busy, perf_stall_a, perf_flush_a);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare("b", e, bus_b.pc_we, bus_b.pc_sel, bus_b.redirect_pc,
              bus_b.ifid_we, bus_b.ifid_flush, bus_b.idex_flush,
              bus_b.md_busy, perf_stall_b, perf_flush_b);
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;

    // Reset then release.
    s = idle(); s.rst = 1; drive(s); drive(s);
    s = idle(); drive(s); drive(s);

    // Load-use on rs, then on rt, then a load to r0 (no stall).
    s = idle(); s.mem_read = 1; s.rd = 5'd8; s.rs = 5'd8; drive(s);
    s = idle(); drive(s);
    s = idle(); s.mem_read = 1; s.rd = 5'd9; s.rt = 5'd9; s.uses_rt = 1; drive(s);
    s = idle(); s.mem_read = 1; s.rd = 5'd9; s.rt = 5'd9; s.uses_rt = 0; drive(s);
    s = idle(); s.mem_read = 1; s.rd = 5'd0; s.rs = 5'd0; drive(s);

    // Mult issue, then mflo held in ID until it advances.
    s = idle(); s.md_op = 1; s.md_use = 1; drive(s);
    for (int i = 0; i < 6; i++) begin s = idle(); s.md_use = 1; drive(s); end
    // Mult issue, then unrelated instructions do not stall.
    s = idle(); s.md_op = 1; s.md_use = 1; drive(s);
    for (int i = 0; i < 5; i++) begin s = idle(); drive(s); end

    // Taken branch, then taken branch under a load-use stall.
    s = idle(); s.br = 1; s.tgt = 32'h0000_3040; drive(s);
    s = idle(); s.br = 1; s.tgt = 32'h0000_3040;
    s.mem_read = 1; s.rd = 5'd8; s.rs = 5'd8; drive(s);
    s = idle(); s.br = 1; s.tgt = 32'h0000_3040; drive(s);

    // Exception during mult/div occupancy combined with load-use.
    s = idle(); s.md_op = 1; s.md_use = 1; drive(s);
    s = idle(); s.exc = 1; s.md_use = 1;
    s.mem_read = 1; s.rd = 5'd8; s.rs = 5'd8; drive(s);
    for (int i = 0; i < 5; i++) begin s = idle(); s.md_use = 1; drive(s); end

    // Exception coinciding with reset: reset wins.
    s = idle(); s.rst = 1; s.exc = 1; drive(s);
    s = idle(); drive(s);

    // Three load-use stalls and two exceptions, then reset clears counters.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mem_read = 1; s.rd = 5'd5; s.rs = 5'd5; drive(s);
      s = idle(); drive(s);
    end
    for (int i = 0; i < 2; i++) begin s = idle(); s.exc = 1; drive(s); end
    s = idle(); drive(s);
    s = idle(); s.rst = 1; drive(s);
    s = idle(); drive(s);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 99) < 2);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.uses_rt  = $urandom_range(0, 1) == 1;
      s.mem_read = ($urandom_range(0, 99) < 30);
      s.rd       = 5'($urandom_range(0, 3));
      s.md_op    = ($urandom_range(0, 99) < 10);
      s.md_use   = s.md_op || ($urandom_range(0, 99) < 25);
      s.br       = ($urandom_range(0, 99) < 30);
      s.tgt      = $urandom;
      s.exc      = ($urandom_range(0, 99) < 5);
      drive(s);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++)
      @(negedge clk);
    @(negedge clk);
    check("drain_a", cyc, q_a.size(), 0);
    check("drain_b", cyc, q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
